// File: rtl/axi_lite_master_pq.sv
// AXI4-Lite master with independent queued read and write command paths.
// Optional response timeout with DRAIN recovery: define AXI_MASTER_TIMEOUT_EN.

module axi_lite_master_pq_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a push would need.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module axi_lite_master_pq #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_rd_valid,
    output logic                cmd_rd_ready,
    input  logic [ADDR_W-1:0]   cmd_rd_addr,
    input  logic                cmd_wr_valid,
    output logic                cmd_wr_ready,
    input  logic [ADDR_W-1:0]   cmd_wr_addr,
    input  logic [DATA_W-1:0]   cmd_wr_data,
    input  logic [DATA_W/8-1:0] cmd_wr_strb,
    output logic                rsp_rd_valid,
    input  logic                rsp_rd_ready,
    output logic [DATA_W-1:0]   rsp_rd_data,
    output logic [1:0]          rsp_rd_resp,
    output logic                rsp_wr_valid,
    input  logic                rsp_wr_ready,
    output logic [1:0]          rsp_wr_resp,
    output logic [ADDR_W-1:0]   araddr,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready,
    output logic [2:0]          rd_fsm_state,
    output logic [2:0]          wr_fsm_state
);
    localparam int SW = DATA_W / 8;
    localparam int WW = ADDR_W + DATA_W + SW;

    if ((DATA_W % 8) != 0 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_params
        $error("axi_lite_master_pq: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        R_IDLE = 3'd0,
        R_ADDR = 3'd1,
        R_DATA = 3'd2,
        R_RESP = 3'd3
`ifdef AXI_MASTER_TIMEOUT_EN
        , R_DRAIN = 3'd4
`endif
    } rd_state_t;

    typedef enum logic [2:0] {
        W_IDLE = 3'd0,
        W_AW_W = 3'd1,
        W_B    = 3'd2,
        W_RESP = 3'd3
`ifdef AXI_MASTER_TIMEOUT_EN
        , W_DRAIN = 3'd4
`endif
    } wr_state_t;

    rd_state_t rd_state, rd_state_d;
    wr_state_t wr_state, wr_state_d;

    logic              rd_full, rd_empty, rd_pop;
    logic [ADDR_W-1:0] rd_head;
    logic              wr_full, wr_empty, wr_pop;
    logic [WW-1:0]     wr_head;

    logic [ADDR_W-1:0] araddr_d;
    logic              arvalid_d, rready_d, rsp_rd_valid_d;
    logic [DATA_W-1:0] rsp_rd_data_d;
    logic [1:0]        rsp_rd_resp_d;

    logic [ADDR_W-1:0] awaddr_d;
    logic [DATA_W-1:0] wdata_d;
    logic [SW-1:0]     wstrb_d;
    logic              awvalid_d, wvalid_d, bready_d, rsp_wr_valid_d;
    logic [1:0]        rsp_wr_resp_d;
    logic              aw_done, aw_done_d, w_done, w_done_d;

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] rd_cnt, rd_cnt_d, wr_cnt, wr_cnt_d;
`endif

    axi_lite_master_pq_fifo #(.W(ADDR_W), .DEPTH(DEPTH)) u_rd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_rd_valid),
        .push_data (cmd_rd_addr),
        .pop       (rd_pop),
        .head      (rd_head),
        .full      (rd_full),
        .empty     (rd_empty)
    );

    axi_lite_master_pq_fifo #(.W(WW), .DEPTH(DEPTH)) u_wr_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_wr_valid),
        .push_data ({cmd_wr_addr, cmd_wr_data, cmd_wr_strb}),
        .pop       (wr_pop),
        .head      (wr_head),
        .full      (wr_full),
        .empty     (wr_empty)
    );

    assign cmd_rd_ready = !rd_full;
    assign cmd_wr_ready = !wr_full;
    assign rd_fsm_state = rd_state;
    assign wr_fsm_state = wr_state;

    // Read path: every AXI/user output is registered; the comb block computes next values.
    always_comb begin
        rd_state_d     = rd_state;
        araddr_d       = araddr;
        arvalid_d      = arvalid;
        rready_d       = rready;
        rsp_rd_valid_d = rsp_rd_valid;
        rsp_rd_data_d  = rsp_rd_data;
        rsp_rd_resp_d  = rsp_rd_resp;
        rd_pop         = 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
        rd_cnt_d       = rd_cnt;
`endif
        case (rd_state)
            R_IDLE: begin
                if (!rd_empty) begin
                    rd_pop     = 1'b1;
                    araddr_d   = rd_head;
                    arvalid_d  = 1'b1;
                    rd_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                if (arready) begin
                    arvalid_d  = 1'b0;
                    rready_d   = 1'b1;
                    rd_state_d = R_DATA;
`ifdef AXI_MASTER_TIMEOUT_EN
                    rd_cnt_d   = '0;
`endif
                end
            end
            R_DATA: begin
                if (rvalid) begin
                    rsp_rd_data_d  = rdata;
                    rsp_rd_resp_d  = rresp;
                    rready_d       = 1'b0;
                    rsp_rd_valid_d = 1'b1;
                    rd_state_d     = R_RESP;
                end
`ifdef AXI_MASTER_TIMEOUT_EN
                else if (rd_cnt == TW'(TIMEOUT - 1)) begin
                    rsp_rd_data_d  = '0;
                    rsp_rd_resp_d  = 2'b11;
                    rsp_rd_valid_d = 1'b1;
                    rd_state_d     = R_DRAIN;
                end else begin
                    rd_cnt_d = rd_cnt + TW'(1);
                end
`endif
            end
            R_RESP: begin
                if (rsp_rd_ready) begin
                    rsp_rd_valid_d = 1'b0;
                    rd_state_d     = R_IDLE;
                end
            end
`ifdef AXI_MASTER_TIMEOUT_EN
            // Wait for both the user to take the error response and one late beat.
            R_DRAIN: begin
                if (rvalid)       rready_d       = 1'b0;
                if (rsp_rd_ready) rsp_rd_valid_d = 1'b0;
                if ((rvalid || !rready) && (rsp_rd_ready || !rsp_rd_valid))
                    rd_state_d = R_IDLE;
            end
`endif
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Write path: AW and W retire independently; B is accepted only after both.
    always_comb begin
        wr_state_d     = wr_state;
        awaddr_d       = awaddr;
        wdata_d        = wdata;
        wstrb_d        = wstrb;
        awvalid_d      = awvalid;
        wvalid_d       = wvalid;
        bready_d       = bready;
        rsp_wr_valid_d = rsp_wr_valid;
        rsp_wr_resp_d  = rsp_wr_resp;
        aw_done_d      = aw_done;
        w_done_d       = w_done;
        wr_pop         = 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
        wr_cnt_d       = wr_cnt;
`endif
        case (wr_state)
            W_IDLE: begin
                if (!wr_empty) begin
                    wr_pop     = 1'b1;
                    {awaddr_d, wdata_d, wstrb_d} = wr_head;
                    awvalid_d  = 1'b1;
                    wvalid_d   = 1'b1;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    wr_state_d = W_AW_W;
                end
            end
            W_AW_W: begin
                if (awvalid && awready) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wvalid && wready) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    bready_d   = 1'b1;
                    wr_state_d = W_B;
`ifdef AXI_MASTER_TIMEOUT_EN
                    wr_cnt_d   = '0;
`endif
                end
            end
            W_B: begin
                if (bvalid) begin
                    rsp_wr_resp_d  = bresp;
                    bready_d       = 1'b0;
                    rsp_wr_valid_d = 1'b1;
                    wr_state_d     = W_RESP;
                end
`ifdef AXI_MASTER_TIMEOUT_EN
                else if (wr_cnt == TW'(TIMEOUT - 1)) begin
                    rsp_wr_resp_d  = 2'b11;
                    rsp_wr_valid_d = 1'b1;
                    wr_state_d     = W_DRAIN;
                end else begin
                    wr_cnt_d = wr_cnt + TW'(1);
                end
`endif
            end
            W_RESP: begin
                if (rsp_wr_ready) begin
                    rsp_wr_valid_d = 1'b0;
                    wr_state_d     = W_IDLE;
                end
            end
`ifdef AXI_MASTER_TIMEOUT_EN
            W_DRAIN: begin
                if (bvalid)       bready_d       = 1'b0;
                if (rsp_wr_ready) rsp_wr_valid_d = 1'b0;
                if ((bvalid || !bready) && (rsp_wr_ready || !rsp_wr_valid))
                    wr_state_d = W_IDLE;
            end
`endif
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_state     <= R_IDLE;
            araddr       <= '0;
            arvalid      <= 1'b0;
            rready       <= 1'b0;
            rsp_rd_valid <= 1'b0;
            rsp_rd_data  <= '0;
            rsp_rd_resp  <= 2'b00;
`ifdef AXI_MASTER_TIMEOUT_EN
            rd_cnt       <= '0;
`endif
        end else begin
            rd_state     <= rd_state_d;
            araddr       <= araddr_d;
            arvalid      <= arvalid_d;
            rready       <= rready_d;
            rsp_rd_valid <= rsp_rd_valid_d;
            rsp_rd_data  <= rsp_rd_data_d;
            rsp_rd_resp  <= rsp_rd_resp_d;
`ifdef AXI_MASTER_TIMEOUT_EN
            rd_cnt       <= rd_cnt_d;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_state     <= W_IDLE;
            awaddr       <= '0;
            wdata        <= '0;
            wstrb        <= '0;
            awvalid      <= 1'b0;
            wvalid       <= 1'b0;
            bready       <= 1'b0;
            rsp_wr_valid <= 1'b0;
            rsp_wr_resp  <= 2'b00;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
            wr_cnt       <= '0;
`endif
        end else begin
            wr_state     <= wr_state_d;
            awaddr       <= awaddr_d;
            wdata        <= wdata_d;
            wstrb        <= wstrb_d;
            awvalid      <= awvalid_d;
            wvalid       <= wvalid_d;
            bready       <= bready_d;
            rsp_wr_valid <= rsp_wr_valid_d;
            rsp_wr_resp  <= rsp_wr_resp_d;
            aw_done      <= aw_done_d;
            w_done       <= w_done_d;
`ifdef AXI_MASTER_TIMEOUT_EN
            wr_cnt       <= wr_cnt_d;
`endif
        end
    end
endmodule
